// File: rtl/cajero_ctrl.sv
// Cashier/ATM session controller: card insert, PIN check with lockout, deposit/withdrawal on a 64-bit balance.
// Optional inactivity timeout in PIN_ENTRADA / ESPERA_MONTO is enabled by defining CAJERO_TIMEOUT_EN.
module cajero_ctrl #(
  parameter int N_DIGITOS      = 4,
  parameter int MAX_INTENTOS   = 3,
  parameter int TIMEOUT_CICLOS = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   TARJETA_RECIBIDA,
  input  logic                   TIPO_TRNANS,
  input  logic [3:0]             DIGITO,
  input  logic                   DIGITO_STB,
  input  logic [4*N_DIGITOS-1:0] PIN,
  input  logic [31:0]            MONTO,
  input  logic                   MONTO_STB,
  input  logic [63:0]            BALANCE_INICIAL,
  output logic                   ENTREGAR_DINERO,
  output logic                   PIN_INCORRECTO,
  output logic                   ADVERTENCIA,
  output logic                   BLOQUEO,
  output logic                   FONDOS_INSUFICIENTES,
  output logic                   BALANCE_ACTUALIZADO,
  output logic [63:0]            BALANCE
);

  localparam int PIN_W = 4 * N_DIGITOS;
  localparam int DW    = $clog2(N_DIGITOS + 1);
  localparam int AW    = $clog2(MAX_INTENTOS + 1);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(N_DIGITOS - 1);
  localparam logic [AW-1:0] AVISO_CNT  = AW'(MAX_INTENTOS - 1);
  localparam logic [AW-1:0] LOCK_CNT   = AW'(MAX_INTENTOS);

  if (N_DIGITOS < 1 || MAX_INTENTOS < 1 || TIMEOUT_CICLOS < 1 || TIMEOUT_CICLOS > 65535) begin : g_bad_params
    $error("cajero_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    ESPERA_TARJETA,
    PIN_ENTRADA,
    VERIFICAR,
    ESPERA_MONTO,
    DEPOSITO,
    RETIRO,
    BLOQUEADO
  } state_t;

  state_t           state_reg;
  logic             tarjeta_prev_reg, digito_prev_reg, monto_prev_reg;
  logic             tarjeta_edge, digito_edge, monto_edge;
  logic [DW-1:0]    digit_cnt_reg;
  logic [AW-1:0]    attempt_cnt_reg;
  logic [AW-1:0]    attempt_next;
  logic [PIN_W-1:0] shift_reg;
  logic [PIN_W-1:0] shift_next;
  logic             tipo_reg;
  logic [31:0]      monto_reg;
  logic [63:0]      monto_ext;
  logic             fondos_ok;

  assign tarjeta_edge = TARJETA_RECIBIDA & ~tarjeta_prev_reg;
  assign digito_edge  = DIGITO_STB & ~digito_prev_reg;
  assign monto_edge   = MONTO_STB & ~monto_prev_reg;
  assign attempt_next = attempt_cnt_reg + 1'b1;
  assign shift_next   = (shift_reg << 4) | PIN_W'(DIGITO);
  assign monto_ext    = {32'd0, monto_reg};
  assign fondos_ok    = (monto_ext <= BALANCE);

`ifdef CAJERO_TIMEOUT_EN
  logic [15:0] idle_cnt_reg;
  logic        timeout_hit;
  assign timeout_hit = (idle_cnt_reg == 16'(TIMEOUT_CICLOS - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= ESPERA_TARJETA;
      BALANCE              <= BALANCE_INICIAL;
      tarjeta_prev_reg     <= 1'b0;
      digito_prev_reg      <= 1'b0;
      monto_prev_reg       <= 1'b0;
      digit_cnt_reg        <= '0;
      attempt_cnt_reg      <= '0;
      shift_reg            <= '0;
      tipo_reg             <= 1'b0;
      monto_reg            <= '0;
      ENTREGAR_DINERO      <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      ADVERTENCIA          <= 1'b0;
      BLOQUEO              <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      BALANCE_ACTUALIZADO  <= 1'b0;
`ifdef CAJERO_TIMEOUT_EN
      idle_cnt_reg         <= '0;
`endif
    end else begin
      tarjeta_prev_reg     <= TARJETA_RECIBIDA;
      digito_prev_reg      <= DIGITO_STB;
      monto_prev_reg       <= MONTO_STB;
      ENTREGAR_DINERO      <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      BALANCE_ACTUALIZADO  <= 1'b0;

      case (state_reg)
        ESPERA_TARJETA: begin
          if (tarjeta_edge) begin
            state_reg     <= PIN_ENTRADA;
            digit_cnt_reg <= '0;
            shift_reg     <= '0;
          end
        end

        PIN_ENTRADA: begin
          if (digito_edge) begin
            shift_reg     <= shift_next;
            digit_cnt_reg <= digit_cnt_reg + 1'b1;
            if (digit_cnt_reg == LAST_DIGIT) begin
              tipo_reg  <= TIPO_TRNANS;
              state_reg <= VERIFICAR;
            end
          end
`ifdef CAJERO_TIMEOUT_EN
          else if (timeout_hit) begin
            state_reg     <= ESPERA_TARJETA;
            digit_cnt_reg <= '0;
            shift_reg     <= '0;
          end
`endif
        end

        VERIFICAR: begin
          digit_cnt_reg <= '0;
          shift_reg     <= '0;
          if (shift_reg == PIN) begin
            state_reg       <= ESPERA_MONTO;
            attempt_cnt_reg <= '0;
            ADVERTENCIA     <= 1'b0;
          end else begin
            PIN_INCORRECTO  <= 1'b1;
            attempt_cnt_reg <= attempt_next;
            if (attempt_next == LOCK_CNT) begin
              state_reg   <= BLOQUEADO;
              BLOQUEO     <= 1'b1;
              ADVERTENCIA <= 1'b0;
            end else begin
              if (attempt_next == AVISO_CNT) ADVERTENCIA <= 1'b1;
              state_reg <= PIN_ENTRADA;
            end
          end
        end

        ESPERA_MONTO: begin
          if (monto_edge) begin
            monto_reg <= MONTO;
            state_reg <= tipo_reg ? RETIRO : DEPOSITO;
          end
`ifdef CAJERO_TIMEOUT_EN
          else if (timeout_hit) begin
            state_reg <= ESPERA_TARJETA;
          end
`endif
        end

        DEPOSITO: begin
          BALANCE             <= BALANCE + monto_ext;
          BALANCE_ACTUALIZADO <= 1'b1;
          state_reg           <= ESPERA_TARJETA;
        end

        RETIRO: begin
          if (fondos_ok) begin
            BALANCE             <= BALANCE - monto_ext;
            ENTREGAR_DINERO     <= 1'b1;
            BALANCE_ACTUALIZADO <= 1'b1;
            state_reg           <= ESPERA_TARJETA;
          end else begin
            // refused amount keeps the session open for another try
            FONDOS_INSUFICIENTES <= 1'b1;
            state_reg            <= ESPERA_MONTO;
          end
        end

        BLOQUEADO: begin
          BLOQUEO     <= 1'b1;
          ADVERTENCIA <= 1'b0;
        end

        default: state_reg <= ESPERA_TARJETA;
      endcase

`ifdef CAJERO_TIMEOUT_EN
      // idle time counts only while waiting for customer input
      if ((state_reg == PIN_ENTRADA && !digito_edge) ||
          (state_reg == ESPERA_MONTO && !monto_edge))
        idle_cnt_reg <= timeout_hit ? 16'd0 : idle_cnt_reg + 16'd1;
      else
        idle_cnt_reg <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_cajero_ctrl.sv
// Self-checking bench for cajero_ctrl: directed plan scenarios plus randomized sessions vs a transaction-level model.
module tb_cajero_ctrl;

  localparam int MAX_INT = 3;
  localparam int N_DIG   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tarjeta = 1'b0;
  logic        tipo = 1'b0;
  logic [3:0]  digito = 4'd0;
  logic        dig_stb = 1'b0;
  logic [15:0] pin = 16'h1194;
  logic [31:0] monto = 32'd0;
  logic        monto_stb = 1'b0;
  logic [63:0] bal_ini = 64'd20000;

  logic        entregar, pin_err, advert, bloqueo, fondos, upd;
  logic [63:0] balance;

  cajero_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .TARJETA_RECIBIDA    (tarjeta),
    .TIPO_TRNANS         (tipo),
    .DIGITO              (digito),
    .DIGITO_STB          (dig_stb),
    .PIN                 (pin),
    .MONTO               (monto),
    .MONTO_STB           (monto_stb),
    .BALANCE_INICIAL     (bal_ini),
    .ENTREGAR_DINERO     (entregar),
    .PIN_INCORRECTO      (pin_err),
    .ADVERTENCIA         (advert),
    .BLOQUEO             (bloqueo),
    .FONDOS_INSUFICIENTES(fondos),
    .BALANCE_ACTUALIZADO (upd),
    .BALANCE             (balance)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // pulse monitor, sampled on the falling edge
  int   n_e = 0, n_p = 0, n_f = 0, n_u = 0, n_coinc = 0, n_wide = 0;
  logic p_e = 1'b0, p_p = 1'b0, p_f = 1'b0, p_u = 1'b0;
  always @(negedge clk) begin
    if (entregar) n_e++;
    if (pin_err)  n_p++;
    if (fondos)   n_f++;
    if (upd)      n_u++;
    if (entregar && upd) n_coinc++;
    if ((entregar && p_e) || (pin_err && p_p) || (fondos && p_f) || (upd && p_u)) n_wide++;
    p_e = entregar; p_p = pin_err; p_f = fondos; p_u = upd;
  end

  // transaction-level reference model
  longint unsigned bal_m;
  int              att_m;
  bit              lock_m, warn_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bal_m = bal_ini; att_m = 0; lock_m = 0; warn_m = 0;
  endtask

  task automatic insert_card();
    tarjeta = 1'b1;
    tick();
    tarjeta = 1'b0;
    tick();
  endtask

  task automatic press_digit(input logic [3:0] d);
    digito  = d;
    dig_stb = 1'b1;
    tick();
    dig_stb = 1'b0;
    tick();
  endtask

  task automatic enter_pin(input logic [15:0] p);
    for (int i = N_DIG - 1; i >= 0; i--) press_digit(p[4*i +: 4]);
  endtask

  task automatic enter_amount(input logic [31:0] a);
    monto     = a;
    monto_stb = 1'b1;
    tick();
    monto_stb = 1'b0;
    tick();
  endtask

  // one card session; a2 is the retry amount used only if a withdrawal is refused
  task automatic session(input logic [15:0] p, input logic t, input logic [31:0] a,
                         input logic [31:0] a2, input string nm);
    int e0, p0, f0, u0, c0;
    int xe, xp, xf, xu;
    logic [31:0] retry;
    e0 = n_e; p0 = n_p; f0 = n_f; u0 = n_u; c0 = n_coinc;
    xe = 0; xp = 0; xf = 0; xu = 0;
    insert_card();
    tipo = t;
    enter_pin(p);
    if (lock_m) begin
    end else if (p == pin) begin
      att_m = 0; warn_m = 0;
      enter_amount(a);
      if (!t) begin
        bal_m += a; xu = 1;
      end else if (a <= bal_m) begin
        bal_m -= a; xe = 1; xu = 1;
      end else begin
        xf = 1;
        tests++;
        if (balance !== bal_m) begin
          fails++;
          $display("FAIL %s refused_balance: got %0d expected %0d", nm, balance, bal_m);
        end
        retry = (a2 > bal_m) ? bal_m[31:0] : a2;
        enter_amount(retry);
        bal_m -= retry; xe = 1; xu = 1;
      end
    end else begin
      att_m++; xp = 1;
      if (att_m == MAX_INT) begin
        lock_m = 1; warn_m = 0;
      end else if (att_m == MAX_INT - 1) begin
        warn_m = 1;
      end
    end
    tick();
    $display("[TB] session %s pin=%h tipo=%0d monto=%0d -> balance=%0d adv=%0d bloq=%0d",
             nm, p, t, a, balance, advert, bloqueo);
    tests++;
    if (balance !== bal_m) begin
      fails++; $display("FAIL %s balance: got %0d expected %0d", nm, balance, bal_m);
    end
    tests++;
    if (advert !== warn_m) begin
      fails++; $display("FAIL %s advertencia: got %0b expected %0b", nm, advert, warn_m);
    end
    tests++;
    if (bloqueo !== lock_m) begin
      fails++; $display("FAIL %s bloqueo: got %0b expected %0b", nm, bloqueo, lock_m);
    end
    tests++;
    if ((n_e - e0) !== xe || (n_coinc - c0) !== xe) begin
      fails++; $display("FAIL %s entregar_pulses: got %0d (coincident %0d) expected %0d", nm, n_e - e0, n_coinc - c0, xe);
    end
    tests++;
    if ((n_u - u0) !== xu) begin
      fails++; $display("FAIL %s update_pulses: got %0d expected %0d", nm, n_u - u0, xu);
    end
    tests++;
    if ((n_p - p0) !== xp) begin
      fails++; $display("FAIL %s pin_err_pulses: got %0d expected %0d", nm, n_p - p0, xp);
    end
    tests++;
    if ((n_f - f0) !== xf) begin
      fails++; $display("FAIL %s fondos_pulses: got %0d expected %0d", nm, n_f - f0, xf);
    end
  endtask

  task automatic test_reset();
    bal_ini = 64'd20000;
    rst = 1'b1;
    tick();
    tick();
    $display("[TB] reset balance=%0d", balance);
    tests++;
    if (balance !== 64'd20000) begin
      fails++; $display("FAIL reset_balance: got %0d expected 20000", balance);
    end
    tests++;
    if ({entregar, pin_err, advert, bloqueo, fondos, upd} !== 6'b0) begin
      fails++; $display("FAIL reset_outputs: got %b expected 000000", {entregar, pin_err, advert, bloqueo, fondos, upd});
    end
    rst = 1'b0;
    tick();
    bal_m = bal_ini; att_m = 0; lock_m = 0; warn_m = 0;
  endtask

  task automatic test_deposit();
    session(16'h1194, 1'b0, 32'd15000, 32'd0, "deposit");
    tests++;
    if (balance !== 64'd35000) begin
      fails++; $display("FAIL deposit_value: got %0d expected 35000", balance);
    end
  endtask

  task automatic test_withdrawal();
    session(16'h1194, 1'b1, 32'd15000, 32'd0, "withdrawal");
    tests++;
    if (balance !== 64'd20000) begin
      fails++; $display("FAIL withdrawal_value: got %0d expected 20000", balance);
    end
  endtask

  task automatic test_insufficient();
    session(16'h1194, 1'b1, 32'd45000, 32'd10000, "insufficient");
    tests++;
    if (balance !== 64'd10000) begin
      fails++; $display("FAIL insufficient_value: got %0d expected 10000", balance);
    end
  endtask

  task automatic test_lockout();
    session(16'h1195, 1'b0, 32'd1, 32'd0, "wrong1");
    session(16'h1195, 1'b0, 32'd1, 32'd0, "wrong2");
    // third attempt by hand to check the verdict latency
    press_digit(4'd1);
    press_digit(4'd1);
    press_digit(4'd9);
    digito  = 4'd5;
    dig_stb = 1'b1;
    tick();
    dig_stb = 1'b0;
    tests++;
    if (pin_err !== 1'b0) begin
      fails++; $display("FAIL lock_latency_early: got %0b expected 0", pin_err);
    end
    tick();
    $display("[TB] third wrong pin: pin_err=%0b bloqueo=%0b", pin_err, bloqueo);
    tests++;
    if (pin_err !== 1'b1 || bloqueo !== 1'b1 || advert !== 1'b0) begin
      fails++; $display("FAIL lock_verdict: got err=%0b bloq=%0b adv=%0b expected 1 1 0", pin_err, bloqueo, advert);
    end
    att_m = MAX_INT; lock_m = 1; warn_m = 0;
    tick();
    session(16'h1194, 1'b0, 32'd500, 32'd0, "locked_ignored");
    do_reset();
    tests++;
    if (bloqueo !== 1'b0 || balance !== bal_ini) begin
      fails++; $display("FAIL unlock_reset: got bloq=%0b bal=%0d expected 0 %0d", bloqueo, balance, bal_ini);
    end
  endtask

  task automatic test_held_strobe();
    int p0, u0;
    p0 = n_p; u0 = n_u;
    insert_card();
    tipo    = 1'b0;
    digito  = 4'd1;
    dig_stb = 1'b1;
    repeat (5) tick();
    dig_stb = 1'b0;
    tick();
    press_digit(4'd1);
    press_digit(4'd9);
    press_digit(4'd4);
    enter_amount(32'd777);
    tick();
    bal_m += 777;
    $display("[TB] held strobe: balance=%0d pin_err=%0d", balance, n_p - p0);
    tests++;
    if (balance !== bal_m || (n_p - p0) !== 0 || (n_u - u0) !== 1) begin
      fails++; $display("FAIL held_strobe: got bal=%0d err=%0d upd=%0d expected %0d 0 1", balance, n_p - p0, n_u - u0, bal_m);
    end
  endtask

  task automatic test_reset_midop();
    int u0;
    bal_ini = 64'd55555;
    insert_card();
    tipo = 1'b0;
    enter_pin(16'h1194);
    u0 = n_u;
    monto     = 32'd500;
    monto_stb = 1'b1;
    tick();
    monto_stb = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    bal_m = bal_ini; att_m = 0; lock_m = 0; warn_m = 0;
    $display("[TB] reset mid-deposit: balance=%0d", balance);
    tests++;
    if (balance !== 64'd55555 || (n_u - u0) !== 0) begin
      fails++; $display("FAIL reset_midop: got bal=%0d upd=%0d expected 55555 0", balance, n_u - u0);
    end
  endtask

  task automatic test_random();
    logic [15:0] p;
    logic        t;
    logic [31:0] a, a2;
    for (int i = 0; i < 40; i++) begin
      if (lock_m) do_reset();
      p  = ($urandom_range(0, 9) < 7) ? pin : (pin ^ 16'($urandom_range(1, 65535)));
      t  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 60000));
      a2 = 32'($urandom_range(0, 30000));
      session(p, t, a, a2, $sformatf("rand%0d", i));
    end
  endtask

`ifdef CAJERO_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    session(16'h0000, 1'b0, 32'd1, 32'd0, "to_wrong1");
    press_digit(4'd1);
    press_digit(4'd1);
    repeat (70) tick();
    session(16'h2222, 1'b0, 32'd1, 32'd0, "to_wrong2");
    tests++;
    if (advert !== 1'b1) begin
      fails++; $display("FAIL timeout_attempts: got adv=%0b expected 1", advert);
    end
    // abandon the pending PIN entry, then a fresh correct PIN must work
    press_digit(4'd3);
    repeat (70) tick();
    session(16'h1194, 1'b0, 32'd321, 32'd0, "to_fresh");
  endtask
`endif

  task automatic test_wide_pulses();
    tests++;
    if (n_wide !== 0) begin
      fails++; $display("FAIL pulse_width: got %0d multi-cycle pulses expected 0", n_wide);
    end
  endtask

  initial begin
    test_reset();
    test_deposit();
    test_withdrawal();
    test_insufficient();
    test_lockout();
    test_held_strobe();
    test_reset_midop();
    test_random();
`ifdef CAJERO_TIMEOUT_EN
    test_timeout();
`endif
    test_wide_pulses();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cajero_ctrl.md
Name: cajero_ctrl

Overview:
- Cashier/ATM transaction controller for single-card sessions.
- It is the responder to the ATM stimulus driver: it consumes card-insert, PIN digit, transaction-type and amount strobes, and produces dispense, PIN-error, warning, lock, insufficient-funds and balance-updated indications.
- Holds the account balance register and the PIN attempt counter.
- Sits between the keypad/card front end and the cash dispenser.

Parameters:
- N_DIGITOS, 4, PIN digits per attempt; PIN is 4*N_DIGITOS bits.
- MAX_INTENTOS, 3, failed attempts before lock.
- TIMEOUT_CICLOS, 64, idle cycles before session abort; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- TARJETA_RECIBIDA  in  1  card inserted, level; the rising edge starts a session.
- TIPO_TRNANS  in  1  0 = deposit, 1 = withdrawal; latched on the last-digit capture.
- DIGITO  in  4  BCD digit under entry.
- DIGITO_STB  in  1  digit strobe; the rising edge captures DIGITO.
- PIN  in  16  stored card PIN, N_DIGITOS nibbles, MS nibble = first digit.
- MONTO  in  32  transaction amount.
- MONTO_STB  in  1  amount strobe; the rising edge captures MONTO.
- BALANCE_INICIAL  in  64  balance loaded on reset.
- ENTREGAR_DINERO  out  1  one-cycle pulse: cash dispense.
- PIN_INCORRECTO  out  1  one-cycle pulse per wrong PIN.
- ADVERTENCIA  out  1  level: one attempt remaining.
- BLOQUEO  out  1  level: controller locked.
- FONDOS_INSUFICIENTES  out  1  one-cycle pulse: withdrawal refused.
- BALANCE_ACTUALIZADO  out  1  one-cycle pulse: balance written.
- BALANCE  out  64  current balance.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State = ESPERA_TARJETA; BALANCE = BALANCE_INICIAL.
  - Attempt counter, digit counter, shift register and edge-detect flops = 0.
  - All other outputs = 0.
- Strobe handling: every strobe input goes through a one-flop edge detector. A strobe held high counts once.
- ESPERA_TARJETA:
  - TARJETA_RECIBIDA rising edge -> PIN_ENTRADA; clears digit counter and shift register.
  - The attempt counter is not cleared here; only rst clears it.
- PIN_ENTRADA:
  - Each DIGITO_STB edge shifts DIGITO into the LS nibble and increments the digit counter.
  - The N_DIGITOS-th capture also latches TIPO_TRNANS, then -> VERIFICAR.
- VERIFICAR (1 cycle):
  - Match -> ESPERA_MONTO; attempt counter = 0; ADVERTENCIA = 0.
  - Mismatch -> PIN_INCORRECTO pulses and the attempt counter increments.
    - New count == MAX_INTENTOS-1 -> ADVERTENCIA = 1.
    - New count == MAX_INTENTOS -> BLOQUEADO.
    - Otherwise -> PIN_ENTRADA with the digit counter cleared.
- ESPERA_MONTO: a MONTO_STB edge captures MONTO and goes to DEPOSITO or RETIRO according to the latched type.
- DEPOSITO (1 cycle):
  - BALANCE += zero-extended MONTO, modulo 2^64.
  - BALANCE_ACTUALIZADO pulses; -> ESPERA_TARJETA.
- RETIRO (1 cycle):
  - If MONTO <= BALANCE: BALANCE -= MONTO; ENTREGAR_DINERO and BALANCE_ACTUALIZADO pulse in the same cycle; -> ESPERA_TARJETA.
  - Otherwise: FONDOS_INSUFICIENTES pulses, BALANCE is unchanged, -> ESPERA_MONTO so the customer may enter a new amount.
- BLOQUEADO:
  - BLOQUEO = 1; ADVERTENCIA = 0.
  - All strobes and card inserts are ignored; only rst exits.
- Latency:
  - Last digit edge -> verdict: 2 cycles (edge-detect flop + VERIFICAR).
  - MONTO_STB edge -> result pulses: 2 cycles.
- Simultaneous strobes: only the strobe relevant to the current state is honoured; others are dropped, not queued.
- Card events: a TARJETA_RECIBIDA edge outside ESPERA_TARJETA is ignored.
- Reset mid-session: aborts immediately; BALANCE reloads BALANCE_INICIAL. Any in-flight deposit is lost.

Optional Feature:
- Macro: CAJERO_TIMEOUT_EN.
- Defined:
  - A 16-bit inactivity counter runs in PIN_ENTRADA and ESPERA_MONTO and clears on any accepted strobe.
  - On reaching TIMEOUT_CICLOS the session aborts to ESPERA_TARJETA with no pulses. Partial digits are discarded; the attempt counter is unchanged.
- Undefined: no counter; these states wait indefinitely.

Test Plan:
- Deposit: rst, BALANCE_INICIAL=20000, PIN=16'h1194, card, digits 1,1,9,4, TIPO=0, MONTO=15000 strobe -> BALANCE_ACTUALIZADO pulse, BALANCE=35000, ENTREGAR_DINERO=0.
- Withdrawal: continuing, TIPO=1, PIN 1194, MONTO=15000 -> ENTREGAR_DINERO and BALANCE_ACTUALIZADO pulse in the same cycle, BALANCE=20000.
- Lockout: digits 1,1,9,5 entered three times -> PIN_INCORRECTO pulse x3; ADVERTENCIA=1 after the 2nd; BLOQUEO=1 after the 3rd; a following correct PIN is ignored; rst clears BLOQUEO.
- Insufficient funds: BALANCE=20000, withdraw 45000 -> FONDOS_INSUFICIENTES pulse, BALANCE unchanged, state ESPERA_MONTO; then 10000 -> ENTREGAR_DINERO, BALANCE=10000.
- Held strobe / reset mid-op: DIGITO_STB held high 5 cycles -> exactly one digit captured. rst asserted after a deposit MONTO_STB edge but before the update -> BALANCE=BALANCE_INICIAL, no BALANCE_ACTUALIZADO.
- CAJERO_TIMEOUT_EN, TIMEOUT_CICLOS=64: card + 2 digits, then 64 idle cycles -> back to ESPERA_TARJETA; fresh PIN 1194 accepted; attempt counter unchanged.
